// File: rtl/divide.sv
// Iterative restoring divider, one quotient bit per clock, begin/end level handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module divide #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_begin,
  input  logic [WIDTH-1:0] div_op1,
  input  logic [WIDTH-1:0] div_op2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             div_end
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  logic s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    mag1    = div_op1[WIDTH-1] ? -div_op1 : div_op1;
    mag2    = div_op2[WIDTH-1] ? -div_op2 : div_op2;
    quo_fix = (s1_q ^ s2_q) ? -dvd_nx : dvd_nx;
    rem_fix = s1_q ? -rem_nx : rem_nx;
  end
`else
  always_comb begin
    mag1    = div_op1;
    mag2    = div_op2;
    quo_fix = dvd_nx;
    rem_fix = rem_nx;
  end
`endif

  // Dividend register doubles as the quotient register: each step shifts out
  // the next dividend bit and shifts in the new quotient bit.
  always_comb begin
    trial  = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_nx = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
    dvd_nx = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    s1_d    = s1_q;
    s2_d    = s2_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (div_begin) begin
          rem_d = '0;
          dvd_d = mag1;
          dvs_d = mag2;
          cnt_d = '0;
`ifdef DIV_SIGNED_EN
          s1_d  = div_op1[WIDTH-1];
          s2_d  = div_op2[WIDTH-1];
`endif
          if (div_op2 == '0) begin
            quo_d   = '1;
            remo_d  = div_op1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = quo_fix;
          remo_d  = rem_fix;
          state_d = DONE;
        end
      end
      DONE: state_d = div_begin ? HOLD : IDLE;
      HOLD: if (!div_begin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      s1_q    <= s1_d;
      s2_q    <= s2_d;
`endif
    end
  end

  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign div_end     = (state_q == DONE);

endmodule
